gen_ux: RTL and testbench
=========================

Name: gen_ux

Overview:
- Button-conditioning and value-generator block for a 50 MHz system.
- Divides clk down to a 1 ms clock-enable strobe (ce1ms).
- Synchronises the raw push-button BTN and samples it once per millisecond to produce the filtered level Ux.
- Emits single-cycle step strobes (ceo) on a press and on auto-repeat while held; each strobe moves the 16-bit up/down value Xf, which feeds downstream display/DAC logic.

Parameters:
- CE_DIV, 50000, clk cycles per ce1ms period (1 ms at 50 MHz).
- REP_DLY, 500, ce1ms ticks Ux must stay high before auto-repeat starts.
- REP_PER, 100, ce1ms ticks between auto-repeat strobes.

Ports:
- clk  input  1  system clock, 50 MHz, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- BTN  input  1  raw asynchronous push-button level, active high.
- up  input  1  count direction: 1 = increment Xf, 0 = decrement Xf.
- ce1ms  output  1  one-clk-wide strobe every CE_DIV clocks.
- Ux  output  1  filtered button level, updated only on ce1ms.
- ceo  output  1  one-clk-wide step strobe.
- Xf  output  16  current value, unsigned.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clock port clk, reset port rst).
- While rst=1 at a clk edge:
  - ce1ms, Ux, ceo = 0; Xf = 16'h0000.
  - Divider count, hold count and both synchroniser flops are cleared.
- Reset has priority over every other event, including mid-press and mid-repeat.
- Divider:
  - Counter counts 0..CE_DIV-1 and wraps.
  - ce1ms=1 exactly in the cycle where the counter equals CE_DIV-1.
  - The first ce1ms after reset release comes CE_DIV cycles later; period is exactly CE_DIV.
- Synchroniser: BTN passes through two flops to give btn_s, a 2-cycle latency; there is no other filtering.
- Ux: on each clk edge where ce1ms=1, Ux <= btn_s; otherwise Ux holds.
  - A press or release is therefore seen within 1 ms + 2 clk.
  - A BTN pulse shorter than one ce1ms period that contains no ce1ms is ignored.
- Press strobe: ceo=1 for exactly one clk in the cycle immediately after Ux changes 0->1.
- Hold counter:
  - While Ux=1, a tick counter (at least 10 bits) increments on each ce1ms.
  - When it reaches REP_DLY, ceo pulses once and the counter reloads to REP_DLY-REP_PER.
  - This gives a repeat strobe every REP_PER ticks thereafter.
  - While Ux=0 the counter is held at 0.
  - A release (Ux 1->0) produces no strobe.
- Strobe width: ceo is never high for two consecutive cycles. Because press and repeat strobes are both ce1ms-derived, they cannot coincide.
- Xf update:
  - On a clk edge with ceo=1: Xf <= Xf+1 if up=1, else Xf-1.
  - Xf reflects the step one clk after the ceo cycle.
  - up is sampled in that same cycle; changing up at other times has no effect.
- Wrap-around is modulo 2^16: 16'hFFFF+1 -> 16'h0000, and 16'h0000-1 -> 16'hFFFF. No saturation and no flags.

Test Plan:
- Reset: rst=1 for 5 clk with BTN=1 -> ce1ms=0, Ux=0, ceo=0, Xf=0 throughout; after release, first ce1ms exactly CE_DIV clocks later, then every CE_DIV.
- Single press: up=1, BTN=1 for 1 ms (50,000 clk) starting 100 ns after reset release.
  - Ux=1 for one ce1ms period.
  - Exactly one ceo pulse, one clk wide.
  - Xf=1 afterwards; no further change after release.
- Down and wrap: Xf=0, up=0, one press -> Xf=16'hFFFF; then up=1, one press -> Xf=16'h0000.
- Auto-repeat: use CE_DIV=10, REP_DLY=5, REP_PER=2 for simulation speed; hold BTN, up=1.
  - ceo strobes at Ux rise, then 5 ticks later, then every 2 ticks.
  - Xf increments by 1 per strobe; strobes stop when Ux falls.
- Glitch rejection: BTN high for 3 clk placed between ce1ms strobes -> Ux stays 0, no ceo, Xf unchanged.
- Reset mid-repeat: assert rst while Ux=1 and repeating -> all outputs 0 next edge; after release with BTN still high, a fresh press strobe occurs on the first ce1ms sampling.

Source files
------------

// File: rtl/gen_ux.sv
// rtl/gen_ux.sv - button conditioner: 1 ms strobe, synchroniser, press/auto-repeat step strobes, 16-bit up/down value
`timescale 1ns/1ps

module gen_ux #(
  parameter int CE_DIV  = 50000,
  parameter int REP_DLY = 500,
  parameter int REP_PER = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        BTN,
  input  logic        up,
  output logic        ce1ms,
  output logic        Ux,
  output logic        ceo,
  output logic [15:0] Xf
);

  localparam int DIV_W  = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;
  localparam int HOLD_W = ($clog2(REP_DLY + 1) > 10) ? $clog2(REP_DLY + 1) : 10;

  localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(CE_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_TOP    = HOLD_W'(REP_DLY);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REP_DLY - REP_PER);

  logic [DIV_W-1:0]  r_div;
  logic              r_btn_m;
  logic              r_btn_s;
  logic              r_ux;
  logic              r_ceo;
  logic [HOLD_W-1:0] r_hold;
  logic [15:0]       r_xf;

  logic              w_ce1ms;
  logic [HOLD_W-1:0] w_hold_inc;
  logic              w_press;
  logic              w_repeat;

  assign w_ce1ms    = (r_div == DIV_LAST);
  assign w_hold_inc = r_hold + 1'b1;

  // Press fires on the tick where Ux is about to rise; repeat only while Ux stays high.
  assign w_press  = w_ce1ms & r_btn_s & ~r_ux;
  assign w_repeat = w_ce1ms & r_btn_s & r_ux & (w_hold_inc == HOLD_TOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div   <= '0;
      r_btn_m <= 1'b0;
      r_btn_s <= 1'b0;
      r_ux    <= 1'b0;
      r_ceo   <= 1'b0;
      r_hold  <= '0;
      r_xf    <= 16'h0000;
    end else begin
      r_div   <= w_ce1ms ? '0 : r_div + 1'b1;
      r_btn_m <= BTN;
      r_btn_s <= r_btn_m;

      if (w_ce1ms) begin
        r_ux <= r_btn_s;
      end

      r_ceo <= w_press | w_repeat;

      // Reloading below the top makes every later strobe REP_PER ticks apart.
      if (!r_ux) begin
        r_hold <= '0;
      end else if (w_ce1ms && r_btn_s) begin
        r_hold <= w_repeat ? HOLD_RELOAD : w_hold_inc;
      end

      if (r_ceo) begin
        r_xf <= up ? r_xf + 16'd1 : r_xf - 16'd1;
      end
    end
  end

  assign ce1ms = w_ce1ms;
  assign Ux    = r_ux;
  assign ceo   = r_ceo;
  assign Xf    = r_xf;

endmodule

// File: tb/tb_gen_ux.sv
// tb/tb_gen_ux.sv - self-checking bench for gen_ux: vector table, directed corner sequences, random run vs model
`timescale 1ns/1ps

module tb_gen_ux;

  localparam int CE_DIV  = 10;
  localparam int REP_DLY = 5;
  localparam int REP_PER = 2;

  logic        clk;
  logic        rst;
  logic        BTN;
  logic        up;
  logic        ce1ms;
  logic        Ux;
  logic        ceo;
  logic [15:0] Xf;

  int checks   = 0;
  int failures = 0;

  gen_ux #(
    .CE_DIV (CE_DIV),
    .REP_DLY(REP_DLY),
    .REP_PER(REP_PER)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .BTN  (BTN),
    .up   (up),
    .ce1ms(ce1ms),
    .Ux   (Ux),
    .ceo  (ceo),
    .Xf   (Xf)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference model: cycles since reset, raw button history, tick-level press/repeat rules.
  int          m_cyc;
  bit          m_hist[$];
  bit          m_ux;
  int          m_cnt;
  bit          m_ceo;
  logic [15:0] m_xf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit b, input bit u);
    bit tick;
    bit btn_s;
    bit new_ceo;
    if (r) begin
      m_cyc = 0;
      m_hist.delete();
      m_hist.push_back(1'b0);
      m_hist.push_back(1'b0);
      m_ux  = 1'b0;
      m_cnt = 0;
      m_ceo = 1'b0;
      m_xf  = 16'h0000;
    end else begin
      tick    = ((m_cyc % CE_DIV) == CE_DIV - 1);
      btn_s   = m_hist[0];
      new_ceo = 1'b0;
      if (m_ceo) m_xf = u ? m_xf + 16'd1 : m_xf - 16'd1;
      if (tick) begin
        if (btn_s && !m_ux) begin
          new_ceo = 1'b1;
          m_cnt   = 0;
        end else if (btn_s && m_ux) begin
          m_cnt++;
          if (m_cnt == REP_DLY) begin
            new_ceo = 1'b1;
            m_cnt   = REP_DLY - REP_PER;
          end
        end else begin
          m_cnt = 0;
        end
        m_ux = btn_s;
      end
      m_ceo = new_ceo;
      void'(m_hist.pop_front());
      m_hist.push_back(b);
      m_cyc++;
    end
  endtask

  // Called at a negedge: drive, take one rising edge, then compare at the next negedge.
  task automatic step(input bit r, input bit b, input bit u);
    rst = r;
    BTN = b;
    up  = u;
    @(posedge clk);
    model_edge(r, b, u);
    @(negedge clk);
    check("ce1ms", 32'(ce1ms), 32'((m_cyc % CE_DIV) == CE_DIV - 1));
    check("Ux",    32'(Ux),    32'(m_ux));
    check("ceo",   32'(ceo),   32'(m_ceo));
    check("Xf",    32'(Xf),    32'(m_xf));
  endtask

  typedef struct {
    bit          rst;
    bit          btn;
    bit          up;
    int          ncyc;
    bit          chk;
    logic [15:0] exp_xf;
    bit          exp_ux;
  } vec_t;

  vec_t vecs[14];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int first_ce;
    int second_ce;
    int seen_ux;
    int seen_ceo;
    int ceo_at;
    int run_left;
    bit rb;
    bit ru;
    bit rr;

    vecs[0]  = '{1'b1, 1'b1, 1'b1,   5, 1'b1, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1,   3, 1'b0, 16'h0000, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1,  10, 1'b0, 16'h0000, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1,  30, 1'b1, 16'h0001, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0,   2, 1'b1, 16'h0000, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0,   3, 1'b0, 16'h0000, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0,  10, 1'b0, 16'h0000, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0,  30, 1'b1, 16'hFFFF, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1,  10, 1'b0, 16'h0000, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1,  30, 1'b1, 16'h0000, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 100, 1'b1, 16'h0004, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b1,  30, 1'b1, 16'h0004, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 100, 1'b1, 16'h0000, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b0,  30, 1'b1, 16'h0000, 1'b0};

    rst = 1'b1;
    BTN = 1'b1;
    up  = 1'b1;
    @(negedge clk);

    // Reset held with BTN high: everything stays at zero.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b1);
      check("rst_ce1ms", 32'(ce1ms), 32'd0);
      check("rst_Ux",    32'(Ux),    32'd0);
      check("rst_ceo",   32'(ceo),   32'd0);
      check("rst_Xf",    32'(Xf),    32'd0);
    end

    // ce1ms is high during the CE_DIV-th clock period after the last reset edge, then every CE_DIV.
    first_ce  = -1;
    second_ce = -1;
    for (int i = 1; i <= 4 * CE_DIV; i++) begin
      step(1'b0, 1'b0, 1'b1);
      if (ce1ms === 1'b1) begin
        if (first_ce < 0) first_ce = i;
        else if (second_ce < 0) second_ce = i;
      end
    end
    check("first_ce1ms_step",  32'(first_ce),  32'(CE_DIV - 1));
    check("second_ce1ms_step", 32'(second_ce), 32'(2 * CE_DIV - 1));

    // Table: single press, down-wrap, up-wrap, auto-repeat up and down.
    for (int v = 0; v < 14; v++) begin
      for (int c = 0; c < vecs[v].ncyc; c++) step(vecs[v].rst, vecs[v].btn, vecs[v].up);
      if (vecs[v].chk) begin
        check($sformatf("vec%0d_Xf", v), 32'(Xf), 32'(vecs[v].exp_xf));
        check($sformatf("vec%0d_Ux", v), 32'(Ux), 32'(vecs[v].exp_ux));
      end
    end

    // Glitch: 3-clk pulse placed just after a tick never reaches a sample point.
    begin : glitch
      int found;
      found = 0;
      for (int i = 0; i < 3 * CE_DIV && found == 0; i++) begin
        step(1'b0, 1'b0, 1'b1);
        if (ce1ms === 1'b1) found = 1;
      end
      check("glitch_sync_found", 32'(found), 32'd1);
      step(1'b0, 1'b0, 1'b1);
      seen_ux  = 0;
      seen_ceo = 0;
      for (int i = 0; i < 3; i++) begin
        step(1'b0, 1'b1, 1'b1);
        if (Ux === 1'b1) seen_ux++;
        if (ceo === 1'b1) seen_ceo++;
      end
      for (int i = 0; i < 3 * CE_DIV; i++) begin
        step(1'b0, 1'b0, 1'b1);
        if (Ux === 1'b1) seen_ux++;
        if (ceo === 1'b1) seen_ceo++;
      end
      check("glitch_ux",  32'(seen_ux),  32'd0);
      check("glitch_ceo", 32'(seen_ceo), 32'd0);
      check("glitch_Xf",  32'(Xf),       32'h0000);
    end

    // Reset while repeating, then a fresh press strobe on the first tick after release.
    for (int i = 0; i < 8 * CE_DIV; i++) step(1'b0, 1'b1, 1'b1);
    check("midrep_Ux_high", 32'(Ux), 32'd1);
    step(1'b1, 1'b1, 1'b1);
    check("midrep_rst_ce1ms", 32'(ce1ms), 32'd0);
    check("midrep_rst_Ux",    32'(Ux),    32'd0);
    check("midrep_rst_ceo",   32'(ceo),   32'd0);
    check("midrep_rst_Xf",    32'(Xf),    32'd0);
    ceo_at = -1;
    for (int i = 1; i <= 3 * CE_DIV && ceo_at < 0; i++) begin
      step(1'b0, 1'b1, 1'b1);
      if (ceo === 1'b1) ceo_at = i;
    end
    check("midrep_first_ceo_step", 32'(ceo_at), 32'(CE_DIV));
    step(1'b0, 1'b1, 1'b1);
    check("midrep_Xf_after_press", 32'(Xf), 32'h0001);
    for (int i = 0; i < 3 * CE_DIV; i++) step(1'b0, 1'b0, 1'b1);

    // Random runs of button level, direction flips and rare resets.
    run_left = 0;
    rb = 1'b0;
    ru = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        rb = ~rb;
        run_left = $urandom_range(1, 120);
      end
      run_left--;
      if ($urandom_range(0, 3) == 0) ru = $urandom_range(0, 1) == 1;
      rr = ($urandom_range(0, 499) == 0);
      step(rr, rb, ru);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
